alu_exec_stage: RTL and testbench
=================================

ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  decoded instruction present this cycle.
REQ-005 SHALL have port alu_ctrl  input  2  ALU control code: 0 add, 1 sub, 2 xor, 3 reserved.
REQ-006 SHALL have port src_a, src_b, imm  input  WIDTH  register operands and sign-extended immediate.
REQ-007 SHALL have port alu_src  input  1  selects imm (1) or src_b (0) as operand B.
REQ-008 SHALL have port fwd_a, fwd_b  input  2  forward select: 0 register, 1 mem_fwd, 2 wb_fwd, 3 register.
REQ-009 SHALL have port mem_fwd, wb_fwd  input  WIDTH  forwarded results from later stages.
REQ-010 SHALL have port branch, reg_write, mem_read, mem_write  input  1  control bits from decode.
REQ-011 SHALL have port rd  input  5  destination register; pc_plus4  input  WIDTH.
REQ-012 SHALL have port stall, flush  input  1  hold / squash the stage register.
REQ-013 SHALL have port out_valid, zero, branch_taken, illegal_op  output  1  registered status.
REQ-014 SHALL have port result, store_data, branch_target  output  WIDTH  registered datapath outputs.
REQ-015 SHALL have port rd_out  output  5; reg_write_out, mem_read_out, mem_write_out  output  1.

Function
REQ-016 Operand A SHALL be the forward-selected src_a; store_data SHALL be forward-selected src_b; operand B SHALL be imm when alu_src=1, else forward-selected src_b.
REQ-017 Result SHALL be A+B, A-B or A^B for codes 0/1/2, modulo 2^WIDTH, no overflow flag; code 3 SHALL yield result 0 and illegal_op=1.
REQ-018 zero SHALL be 1 exactly when the computed result equals 0.
REQ-019 branch_target SHALL be pc_plus4 + (imm shifted left 2), modulo 2^WIDTH.
REQ-020 branch_taken SHALL be branch AND zero AND in_valid AND NOT illegal_op.
REQ-021 All outputs SHALL be registered; latency one cycle from in_valid to out_valid.
REQ-022 Priority per edge SHALL be: rst > flush > stall > load.
REQ-023 flush=1 SHALL load a bubble: out_valid, branch_taken, illegal_op, reg_write_out, mem_read_out, mem_write_out all 0; datapath outputs don't-care.
REQ-024 stall=1 (no flush) SHALL hold every output register unchanged.
REQ-025 Otherwise the register SHALL load; if in_valid=0 it SHALL load a bubble as in REQ-023.
REQ-026 Control outputs (reg_write_out etc.) SHALL never be 1 while out_valid=0.
REQ-027 Simultaneous stall and flush SHALL flush.

Reset
REQ-028 rst SHALL clear all outputs to 0 immediately, independent of clk.
REQ-029 Deassertion SHALL take effect at the next rising edge; the first loaded instruction SHALL appear one cycle later.
REQ-030 rst mid-stall SHALL discard the held instruction.

Structure
REQ-031 ALU control codes (ADD=0, SUB=1, XOR=2) and forward-select codes SHALL live in shared package cpu_pkg, shared with the ALU control decoder.
REQ-032 Combinational arithmetic SHALL be sub-module alu_core (inputs a, b, ctrl; outputs result, zero, illegal); stage register and forwarding muxes in alu_exec_stage.

Verification
REQ-033 src_a=5, src_b=3, ctrl=0, in_valid=1 -> next cycle result=8, zero=0, out_valid=1.
REQ-034 src_a=7, imm=7, alu_src=1, ctrl=1, branch=1, pc_plus4=0x100, imm=7 -> result=0, zero=1, branch_taken=1, branch_target=0x11C.
REQ-035 src_a=0xFFFFFFFF, src_b=1, ctrl=0 -> result=0, zero=1 (wrap); ctrl=2, src_a=0xF0F0, src_b=0xFFFF -> result=0x0F0F.
REQ-036 fwd_a=1, mem_fwd=10, src_a=99, src_b=4, ctrl=1 -> result=6; fwd_b=2, wb_fwd=0x55, mem_write=1 -> store_data=0x55.
REQ-037 Load add, then stall=1 for 3 cycles with new inputs -> outputs unchanged; stall+flush together -> out_valid=0, reg_write_out=0.
REQ-038 ctrl=3 with reg_write=1 -> result=0, illegal_op=1, branch_taken=0; rst asserted mid-cycle -> all outputs 0 before next edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: ALU control and forward-select codes shared across the CPU pipeline
package cpu_pkg;
  typedef enum logic [1:0] {
    ALU_ADD  = 2'd0,
    ALU_SUB  = 2'd1,
    ALU_XOR  = 2'd2,
    ALU_RSVD = 2'd3
  } alu_ctrl_e;
  typedef enum logic [1:0] {
    FWD_REG     = 2'd0,
    FWD_MEM     = 2'd1,
    FWD_WB      = 2'd2,
    FWD_REG_ALT = 2'd3
  } fwd_sel_e;
  function automatic logic is_legal(input logic [1:0] code);
    return code != ALU_RSVD;
  endfunction
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational add/sub/xor with zero and illegal-code flags
module alu_core
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       ctrl,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);
  // reserved code yields zero result and raises illegal
  always_comb begin
    illegal = !is_legal(ctrl);
    result  = ctrl == ALU_ADD ? a + b :
              ctrl == ALU_SUB ? a - b :
              ctrl == ALU_XOR ? a ^ b : '0;
    zero    = result == '0;
  end
endmodule

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: forwarding muxes, ALU and the EX/MEM stage register
module alu_exec_stage
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [1:0]       alu_ctrl,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [WIDTH-1:0] imm,
  input  logic             alu_src,
  input  logic [1:0]       fwd_a,
  input  logic [1:0]       fwd_b,
  input  logic [WIDTH-1:0] mem_fwd,
  input  logic [WIDTH-1:0] wb_fwd,
  input  logic             branch,
  input  logic             reg_write,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [4:0]       rd,
  input  logic [WIDTH-1:0] pc_plus4,
  input  logic             stall,
  input  logic             flush,
  output logic             out_valid,
  output logic             zero,
  output logic             branch_taken,
  output logic             illegal_op,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] store_data,
  output logic [WIDTH-1:0] branch_target,
  output logic [4:0]       rd_out,
  output logic             reg_write_out,
  output logic             mem_read_out,
  output logic             mem_write_out
);
  logic [WIDTH-1:0] op_a, fwd_b_val, op_b, alu_res, target;
  logic             alu_zero, alu_ill, take;
  // operand selection, branch target and branch decision
  always_comb begin
    op_a      = fwd_a == FWD_MEM ? mem_fwd : fwd_a == FWD_WB ? wb_fwd : src_a;
    fwd_b_val = fwd_b == FWD_MEM ? mem_fwd : fwd_b == FWD_WB ? wb_fwd : src_b;
    op_b      = alu_src ? imm : fwd_b_val;
    target    = pc_plus4 + (imm << 2);
    take      = in_valid & branch & alu_zero & ~alu_ill;
  end
  alu_core #(.WIDTH(WIDTH)) u_alu (
    .a      (op_a),
    .b      (op_b),
    .ctrl   (alu_ctrl),
    .result (alu_res),
    .zero   (alu_zero),
    .illegal(alu_ill)
  );
  // stage register: flush squashes control, stall holds, otherwise load (bubble when idle)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid     <= 1'b0;
      zero          <= 1'b0;
      branch_taken  <= 1'b0;
      illegal_op    <= 1'b0;
      result        <= '0;
      store_data    <= '0;
      branch_target <= '0;
      rd_out        <= '0;
      reg_write_out <= 1'b0;
      mem_read_out  <= 1'b0;
      mem_write_out <= 1'b0;
    end else if (flush) begin
      out_valid     <= 1'b0;
      branch_taken  <= 1'b0;
      illegal_op    <= 1'b0;
      reg_write_out <= 1'b0;
      mem_read_out  <= 1'b0;
      mem_write_out <= 1'b0;
    end else if (!stall) begin
      out_valid     <= in_valid;
      zero          <= alu_zero;
      branch_taken  <= take;
      illegal_op    <= in_valid & alu_ill;
      result        <= alu_res;
      store_data    <= fwd_b_val;
      branch_target <= target;
      rd_out        <= rd;
      reg_write_out <= in_valid & reg_write;
      mem_read_out  <= in_valid & mem_read;
      mem_write_out <= in_valid & mem_write;
    end
  end
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: directed vectors with a queue-based scoreboard and a separate monitor
module tb_alu_exec_stage;
  logic        clk = 0, rst;
  logic        in_valid, alu_src, branch, reg_write, mem_read, mem_write, stall, flush;
  logic [1:0]  alu_ctrl, fwd_a, fwd_b;
  logic [31:0] src_a, src_b, imm, mem_fwd, wb_fwd, pc_plus4;
  logic [4:0]  rd;
  logic        out_valid, zero, branch_taken, illegal_op, reg_write_out, mem_read_out, mem_write_out;
  logic [31:0] result, store_data, branch_target;
  logic [4:0]  rd_out;
  int          checks = 0, errors = 0;
  typedef struct {
    int          id;
    logic        v, z, bt, ill, rw, mr, mw;
    logic [4:0]  rd;
    logic [31:0] res, sd, tgt;
  } exp_t;
  exp_t q[$];
  exp_t last;
  always #5 clk = ~clk;
  alu_exec_stage #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .alu_ctrl(alu_ctrl),
    .src_a(src_a), .src_b(src_b), .imm(imm), .alu_src(alu_src),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_fwd(mem_fwd), .wb_fwd(wb_fwd),
    .branch(branch), .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .rd(rd), .pc_plus4(pc_plus4), .stall(stall), .flush(flush),
    .out_valid(out_valid), .zero(zero), .branch_taken(branch_taken), .illegal_op(illegal_op),
    .result(result), .store_data(store_data), .branch_target(branch_target),
    .rd_out(rd_out), .reg_write_out(reg_write_out), .mem_read_out(mem_read_out),
    .mem_write_out(mem_write_out)
  );
  function automatic exp_t mk(int id, logic v, logic [31:0] res, logic z, logic bt, logic ill,
                              logic rw, logic mr, logic mw, logic [4:0] r, logic [31:0] sd, logic [31:0] tgt);
    exp_t e;
    e.id = id; e.v = v; e.res = res; e.z = z; e.bt = bt; e.ill = ill;
    e.rw = rw; e.mr = mr; e.mw = mw; e.rd = r; e.sd = sd; e.tgt = tgt;
    return e;
  endfunction
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask
  task automatic check_zero(input string tag);
    cmp({tag, "_valid"}, 32'(out_valid), 0);
    cmp({tag, "_zero"}, 32'(zero), 0);
    cmp({tag, "_bt"}, 32'(branch_taken), 0);
    cmp({tag, "_ill"}, 32'(illegal_op), 0);
    cmp({tag, "_result"}, result, 0);
    cmp({tag, "_sd"}, store_data, 0);
    cmp({tag, "_tgt"}, branch_target, 0);
    cmp({tag, "_rd"}, 32'(rd_out), 0);
    cmp({tag, "_ctl"}, {29'd0, reg_write_out, mem_read_out, mem_write_out}, 0);
  endtask
  task automatic defaults();
    in_valid = 0; alu_ctrl = 0; src_a = 0; src_b = 0; imm = 0; alu_src = 0;
    fwd_a = 0; fwd_b = 0; mem_fwd = 0; wb_fwd = 0; branch = 0; reg_write = 0;
    mem_read = 0; mem_write = 0; rd = 0; pc_plus4 = 0; stall = 0; flush = 0;
  endtask
  task automatic step(input exp_t e);
    q.push_back(e);
    last = e;
    @(negedge clk);
  endtask
  // monitor: after every rising edge compare the stage register against the oldest expectation
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        exp_t e;
        string p;
        e = q.pop_front();
        p = $sformatf("v%0d", e.id);
        cmp({p, "_valid"}, 32'(out_valid), 32'(e.v));
        cmp({p, "_bt"}, 32'(branch_taken), 32'(e.bt));
        cmp({p, "_ill"}, 32'(illegal_op), 32'(e.ill));
        cmp({p, "_ctl"}, {29'd0, reg_write_out, mem_read_out, mem_write_out}, {29'd0, e.rw, e.mr, e.mw});
        if (e.v) begin
          cmp({p, "_result"}, result, e.res);
          cmp({p, "_zero"}, 32'(zero), 32'(e.z));
          cmp({p, "_sd"}, store_data, e.sd);
          cmp({p, "_tgt"}, branch_target, e.tgt);
          cmp({p, "_rd"}, 32'(rd_out), 32'(e.rd));
        end
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, errors %0d", errors);
    $fatal(1, "timeout");
  end
  initial begin
    rst = 0;
    defaults();
    #1 rst = 1;
    #2 check_zero("reset_init");
    @(negedge clk); rst = 0;
    @(negedge clk);
    defaults(); in_valid = 1; src_a = 5; src_b = 3; reg_write = 1; rd = 1;
    step(mk(1, 1, 8, 0, 0, 0, 1, 0, 0, 1, 3, 0));
    defaults(); in_valid = 1; src_a = 7; imm = 7; alu_src = 1; alu_ctrl = 1; branch = 1; pc_plus4 = 32'h100;
    step(mk(2, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 32'h11C));
    defaults(); in_valid = 1; src_a = 32'hFFFF_FFFF; src_b = 1;
    step(mk(3, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0));
    defaults(); in_valid = 1; alu_ctrl = 2; src_a = 32'hF0F0; src_b = 32'hFFFF;
    step(mk(4, 1, 32'h0F0F, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF, 0));
    defaults(); in_valid = 1; fwd_a = 1; mem_fwd = 10; src_a = 99; src_b = 4; alu_ctrl = 1;
    step(mk(5, 1, 6, 0, 0, 0, 0, 0, 0, 0, 4, 0));
    defaults(); in_valid = 1; fwd_b = 2; wb_fwd = 32'h55; src_a = 32'h10; src_b = 7; mem_write = 1; rd = 2;
    step(mk(6, 1, 32'h65, 0, 0, 0, 0, 0, 1, 2, 32'h55, 0));
    defaults(); in_valid = 1; alu_ctrl = 3; reg_write = 1; branch = 1; src_a = 1; src_b = 2; rd = 5;
    step(mk(7, 1, 0, 1, 0, 1, 1, 0, 0, 5, 2, 0));
    defaults(); in_valid = 1; fwd_a = 3; fwd_b = 2; src_a = 20; src_b = 1; wb_fwd = 5; alu_ctrl = 1;
    step(mk(8, 1, 15, 0, 0, 0, 0, 0, 0, 0, 5, 0));
    defaults(); in_valid = 1; fwd_b = 3; src_a = 3; src_b = 4; mem_read = 1; rd = 7; imm = 32'h10; pc_plus4 = 32'h200;
    step(mk(9, 1, 7, 0, 0, 0, 0, 1, 0, 7, 4, 32'h240));
    defaults(); reg_write = 1; mem_read = 1; mem_write = 1; branch = 1;
    step(mk(20, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    defaults(); in_valid = 1; src_a = 2; src_b = 2; reg_write = 1; rd = 9;
    step(mk(10, 1, 4, 0, 0, 0, 1, 0, 0, 9, 2, 0));
    for (int i = 0; i < 3; i++) begin
      defaults(); in_valid = 1; stall = 1; src_a = 100 + i; src_b = 1; mem_read = 1; rd = 3;
      step(last);
    end
    defaults(); in_valid = 1; stall = 1; flush = 1; src_a = 1; reg_write = 1;
    step(mk(11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    defaults(); in_valid = 1; src_a = 1; src_b = 1; reg_write = 1; rd = 4;
    step(mk(12, 1, 2, 0, 0, 0, 1, 0, 0, 4, 1, 0));
    defaults(); in_valid = 1; stall = 1; src_a = 50;
    step(last);
    #2 rst = 1;
    #1 check_zero("reset_mid_stall");
    @(negedge clk); rst = 0; defaults();
    @(negedge clk);
    defaults(); in_valid = 1; alu_ctrl = 1; src_a = 9; src_b = 1; reg_write = 1; rd = 6;
    step(mk(13, 1, 8, 0, 0, 0, 1, 0, 0, 6, 1, 0));
    defaults();
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
